// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and decode-side handshake bundle for the fetch unit
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: issues word reads for the PC stream and queues PC-tagged instructions toward decode
module fetch_unit #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              redirect,
  fetch_unit_if.master      bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t                     state_q, state_d;
  logic                       req_q, req_d;
  logic [ADDR_W-1:0]          addr_q, addr_d, tag_q, tag_d;
  logic [CW-1:0]              count_q;
  logic [PW-1:0]              wr_q, rd_q;
  logic [ADDR_W+DATA_W-1:0]   mem_q [DEPTH];
  logic                       push, pop, launch;
  logic [CW:0]                fill;
  assign bus.instr_valid = |count_q;
  assign pop    = bus.instr_valid && bus.instr_ready;
  assign push   = state_q == WAIT && bus.imem_ack && !redirect;
  assign fill   = {1'b0, count_q} + (CW+1)'(push) - (CW+1)'(pop);
  // reset gates launch so nothing is requested while the unit is held in reset
  assign launch = reset && !redirect && fill < (CW+1)'(DEPTH) && (state_q == IDLE || push);
  assign pc_advance     = launch;
  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.instr_out  = bus.instr_valid ? mem_q[rd_q][DATA_W-1:0] : '0;
  assign bus.instr_pc   = bus.instr_valid ? mem_q[rd_q][ADDR_W+DATA_W-1:DATA_W] : '0;
  // next state: an ack always closes the outstanding request, a new launch reopens it
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    case (state_q)
      WAIT: begin
        if (bus.imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (redirect) state_d = DISCARD;
      end
      DISCARD: begin
        if (bus.imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: ;
    endcase
    if (launch) begin
      state_d = WAIT;
      req_d   = 1'b1;
      addr_d  = {pc_in[ADDR_W-1:2], 2'b00};
      tag_d   = pc_in;
    end
  end
  // request/state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
    end
  end
  // FIFO pointers and occupancy; a redirect empties the queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else if (redirect) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) wr_q <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
      if (pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
    end
  end
  // FIFO storage: PC tag in the upper field, instruction in the lower
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {tag_q, bus.imem_rdata};
  end
endmodule
